// File: rtl/game_controller_if.sv
// game_controller_if: game-event inputs and game-status outputs of the game controller
interface game_controller_if;
  logic        frame_i;
  logic        start_i;
  logic        enemy_hit_i;
  logic        player_hit_i;
  logic        enemies_dead_i;
  logic        enemy_landed_i;
  logic [2:0]  state_o;
  logic        play_en_o;
  logic        round_reset_o;
  logic [2:0]  lives_o;
  logic [2:0]  level_o;
  logic [15:0] score_o;
  logic        add_life_o;
  modport master (
    output frame_i, start_i, enemy_hit_i, player_hit_i, enemies_dead_i, enemy_landed_i,
    input  state_o, play_en_o, round_reset_o, lives_o, level_o, score_o, add_life_o
  );
  modport slave (
    input  frame_i, start_i, enemy_hit_i, player_hit_i, enemies_dead_i, enemy_landed_i,
    output state_o, play_en_o, round_reset_o, lives_o, level_o, score_o, add_life_o
  );
endinterface

// File: rtl/game_controller.sv
// game_controller: game flow FSM tracking lives, level and score with frame-timed banners
module game_controller #(
  parameter int lives_init_p    = 3,
  parameter int max_lives_p     = 5,
  parameter int max_level_p     = 7,
  parameter int banner_frames_p = 120,
  parameter int points_p        = 10
) (
  input logic              clk_i,
  input logic              reset_n_async_unsafe_i,
  game_controller_if.slave bus
);
  typedef enum logic [2:0] {idle, banner, play, respawn, clear, game_over} state_t;
  localparam int tw = $clog2(banner_frames_p) + 1;
  localparam logic [tw-1:0] last = tw'(banner_frames_p - 1);
  state_t      state, state_n;
  logic [tw-1:0] timer;
  logic        start_q, press, done, armed;
  logic [2:0]  lives, lives_n, level, level_n;
  logic [15:0] score, score_n;
  logic [16:0] sum;
  logic        rr, rr_n, al, al_n;
  assign press = bus.start_i & ~start_q;
  assign done  = bus.frame_i && timer == last;
  assign sum   = {1'b0, score} + 17'(points_p);
  // State, button history, frame timer (cleared on every state entry, held at its last count) and exit arm
  always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i)
    if (!reset_n_async_unsafe_i) begin
      state   <= idle;
      start_q <= 1'b1;
      timer   <= '0;
      armed   <= 1'b0;
    end else begin
      state   <= state_n;
      start_q <= bus.start_i;
      timer   <= state_n != state ? '0 : (bus.frame_i && timer != last ? timer + 1'b1 : timer);
      armed   <= state_n != state ? 1'b0 : armed | done;
    end
  // Next-state selection; PLAY events are prioritised landed > player hit > wave cleared
  always_comb begin
    state_n = state;
    case (state)
      idle:      state_n = press ? banner : idle;
      banner:    state_n = done ? play : banner;
      play:      state_n = bus.enemy_landed_i ? game_over :
                           bus.player_hit_i   ? (lives <= 3'd1 ? game_over : respawn) :
                           bus.enemies_dead_i ? clear : play;
      respawn:   state_n = done ? banner : respawn;
      clear:     state_n = done ? (level >= 3'(max_level_p) ? game_over : banner) : clear;
      game_over: state_n = armed && press ? idle : game_over;
      default:   state_n = idle;
    endcase
  end
  // Next values of the registered game counters and one-cycle pulses
  always_comb begin
    lives_n = lives;
    level_n = level;
    score_n = score;
    rr_n    = 1'b0;
    al_n    = 1'b0;
    case (state)
      idle: if (press) begin
        lives_n = 3'(lives_init_p);
        level_n = '0;
        score_n = '0;
        rr_n    = 1'b1;
      end
      play: begin
        score_n = bus.enemy_hit_i ? (sum[16] ? 16'hFFFF : sum[15:0]) : score;
        if (bus.enemy_landed_i) lives_n = '0;
        else if (bus.player_hit_i) lives_n = lives <= 3'd1 ? '0 : lives - 1'b1;
        else if (bus.enemies_dead_i && lives < 3'(max_lives_p)) begin
          lives_n = lives + 1'b1;
          al_n    = 1'b1;
        end
      end
      respawn: rr_n = done;
      clear: if (done && level < 3'(max_level_p)) begin
        level_n = level + 1'b1;
        rr_n    = 1'b1;
      end
      default: ;
    endcase
  end
  // Registered counters and pulses
  always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i)
    if (!reset_n_async_unsafe_i) begin
      lives <= '0;
      level <= '0;
      score <= '0;
      rr    <= 1'b0;
      al    <= 1'b0;
    end else begin
      lives <= lives_n;
      level <= level_n;
      score <= score_n;
      rr    <= rr_n;
      al    <= al_n;
    end
  assign bus.state_o       = state;
  assign bus.play_en_o     = state == play;
  assign bus.round_reset_o = rr;
  assign bus.lives_o       = lives;
  assign bus.level_o       = level;
  assign bus.score_o       = score;
  assign bus.add_life_o    = al;
endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter lives_init_p, default 3: lives loaded at game start.
REQ-002 Parameter max_lives_p, default 5: lives ceiling.
REQ-003 Parameter max_level_p, default 7: last level; clearing it returns to GAME_OVER (win).
REQ-004 Parameter banner_frames_p, default 120: frame_i pulses spent in each timed state.
REQ-005 Parameter points_p, default 10: score added per enemy hit.
REQ-006 clk_i  input  1  pixel clock, sole clock domain.
REQ-007 reset_n_async_unsafe_i  input  1  asynchronous, active-low reset.
REQ-008 frame_i  input  1  one-cycle pulse per video frame.
REQ-009 start_i  input  1  synchronized shoot/start button level.
REQ-010 enemy_hit_i  input  1  one-cycle pulse, player bullet destroyed an enemy.
REQ-011 player_hit_i  input  1  one-cycle pulse, player destroyed.
REQ-012 enemies_dead_i  input  1  level, all enemies of the wave destroyed.
REQ-013 enemy_landed_i  input  1  level, enemy wave reached the player row.
REQ-014 state_o  output  3  encoded state: IDLE=0, BANNER=1, PLAY=2, RESPAWN=3, CLEAR=4, GAME_OVER=5.
REQ-015 play_en_o  output  1  high only in PLAY; gates player/enemy motion and firing.
REQ-016 round_reset_o  output  1  one-cycle pulse; player/enemy return to start positions.
REQ-017 lives_o  output  3  remaining lives.
REQ-018 level_o  output  3  current level, 0-based.
REQ-019 score_o  output  16  binary score.
REQ-020 add_life_o  output  1  one-cycle pulse when a life is awarded.

Function
REQ-021 start_i SHALL be rising-edge detected internally; "press" below means one detected edge.
REQ-022 Frame timer SHALL count frame_i pulses; cleared on every state entry; "timer done" means a frame_i pulse arrives while count equals banner_frames_p-1.
REQ-023 IDLE: press -> BANNER; lives:=lives_init_p, level:=0, score:=0, round_reset_o pulses the same cycle as the transition.
REQ-024 BANNER: timer done -> PLAY; press is ignored.
REQ-025 PLAY priority, highest first: enemy_landed_i -> GAME_OVER (lives:=0); player_hit_i -> RESPAWN (lives decremented) or GAME_OVER if lives was 1; enemies_dead_i -> CLEAR.
REQ-026 PLAY: enemy_hit_i adds points_p to score in the same cycle as any transition; score saturates at 16'hFFFF.
REQ-027 enemy_hit_i outside PLAY SHALL be ignored.
REQ-028 RESPAWN: timer done -> BANNER with round_reset_o pulse; level and score unchanged.
REQ-029 CLEAR: timer done -> if level==max_level_p then GAME_OVER, else level+1, BANNER, round_reset_o pulse.
REQ-030 CLEAR entry SHALL award one life (add_life_o pulse) only if lives<max_lives_p; otherwise no pulse, lives unchanged.
REQ-031 GAME_OVER: score and level held; timer done arms exit; subsequent press -> IDLE. A press before timer done is ignored.
REQ-032 play_en_o SHALL be combinational from state (high iff PLAY); the other outputs are registered.
REQ-033 lives SHALL never underflow below 0 or exceed max_lives_p; level SHALL never exceed max_level_p.
REQ-034 Unused state encodings SHALL recover to IDLE on the next cycle.

Reset
REQ-035 Asserting reset_n_async_unsafe_i low SHALL immediately force IDLE, lives=0, level=0, score=0, timer=0, all pulses low, and the edge-detector history=1 (a button held through reset does not start a game).
REQ-036 Reset SHALL take effect mid-operation from any state; the first press after release starts a new game.

Verification
REQ-037 Reset release, start_i pulsed high for 3 cycles -> BANNER, lives=3, level=0, score=0, one round_reset_o pulse; 120 frames later -> PLAY.
REQ-038 In PLAY, 4 enemy_hit_i pulses -> score=40; score preset near saturation, plus one hit -> score=16'hFFFF.
REQ-039 In PLAY with lives=1, player_hit_i and enemies_dead_i asserted in the same cycle -> GAME_OVER, lives=0, no CLEAR.
REQ-040 enemies_dead_i in PLAY with lives=5 -> CLEAR, no add_life_o, lives=5; with lives=2 -> add_life_o pulse, lives=3; after 120 frames -> level=1, BANNER.
REQ-041 Level 7 cleared -> GAME_OVER; press before 120 frames ignored; press after -> IDLE.
REQ-042 Reset asserted mid-RESPAWN with start_i held -> IDLE; no new game until start_i falls and rises again.
